uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port rx, input, width 1, the asynchronous serial line; idle is high.
REQ-006 The block SHALL have port data, output, width 8, the last received byte, held until the next valid byte.
REQ-007 The block SHALL have port valid, output, width 1, a one-cycle pulse when data is updated.
REQ-008 The block SHALL have port frame_err, output, width 1, a one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port busy, output, width 1, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL derive CLKS_PER_BIT = CLK_HZ / BAUD (integer division) and HALF_BIT = CLKS_PER_BIT / 2.
REQ-011 The block SHALL require 4 <= CLKS_PER_BIT <= 65535 and SHALL use a 16-bit bit-period counter.
REQ-012 The block SHALL pass rx through a two-flop synchronizer reset to 1; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 In IDLE, rx_s == 0 SHALL move the FSM to START and clear the counter.
REQ-015 In START, when the counter reaches HALF_BIT-1, the block SHALL re-sample rx_s: a 0 moves to DATA with the counter and bit index cleared; a 1 is a glitch and returns to IDLE with no output pulse.
REQ-016 In DATA, the block SHALL sample rx_s each time the counter reaches CLKS_PER_BIT-1, i.e. at bit centres.
REQ-017 DATA sampling SHALL shift bits LSB first into a shift register, increment a 3-bit index, and move to STOP after index 7.
REQ-018 In STOP, at counter CLKS_PER_BIT-1, rx_s == 1 SHALL load data from the shift register, pulse valid for exactly 1 cycle and return to IDLE in that same cycle.
REQ-019 In STOP, at counter CLKS_PER_BIT-1, rx_s == 0 SHALL pulse frame_err for 1 cycle, leave data and valid unchanged, and move to WAIT_HIGH.
REQ-020 In WAIT_HIGH, the FSM SHALL stay until rx_s == 1 and then go to IDLE, so that a break (line held low) produces exactly one frame_err and no false start.
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 A new start bit SHALL be accepted on the first low rx_s seen in IDLE, including the cycle right after a valid pulse (back-to-back frames with no idle gap).
REQ-023 The counter SHALL clear on every state transition and on every bit-sample event, and SHALL otherwise increment.

Reset
REQ-024 Assertion of rst_n low SHALL immediately force: state IDLE, data 8'h00, valid 0, frame_err 0, busy 0, counter 0, index 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte with no pulse; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-026 The shared package uart_pkg SHALL hold the state encoding and the CLKS_PER_BIT/HALF_BIT computation function, so that it is common with the transmitter.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (width 1, reset value parameterised); the rest SHALL be flat.

Verification (CLK_HZ=100_000_000, BAUD=115200, so CLKS_PER_BIT=868)
REQ-028 Serial frame 0x55 with a good stop bit -> one valid pulse, data=8'h55, frame_err never asserted.
REQ-029 Frames 0xA5 then 0x3C, back-to-back with no idle gap -> two valid pulses, data 8'hA5 then 8'h3C, about 8680 cycles apart.
REQ-030 Low glitch of 200 cycles on an idle line -> no valid, no frame_err, busy returns low after about 434 cycles.
REQ-031 Frame 0xFF with stop bit low, then line held low for 20 bit times -> exactly one frame_err, no valid, busy stays high until rx returns high.
REQ-032 rst_n pulsed low in the middle of bit 4 of frame 0x81 -> outputs reset at once, no pulse; the next frame 0x42 is received correctly.
REQ-033 Loopback from the transmitter, 256 random bytes, both ends at 115200 -> every byte received in order with zero frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - uart_state_e : receive FSM state encoding
//   - CntWidth     : width of the bit-period counter
//   - clks_per_bit : clock cycles per serial bit, CLK_HZ / BAUD (truncating)
//   - half_bit     : half of clks_per_bit, used to reach the start-bit centre
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitHigh = 3'd4
    } uart_state_e;

    localparam int unsigned CntWidth = 16;

    // Integer division truncates; any residual baud error must stay well
    // inside half a bit over one frame.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clks_per_bit(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for an asynchronous input.
// Parameters:
//   Width    : number of independent bits synchronized
//   ResetVal : value both flop stages take while rst_n is low
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles behind d_i
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The line is synchronized, a start bit is qualified at
// its centre, data bits are sampled LSB first at bit centres and the stop
// bit decides between a data update and a framing error.
// Parameters:
//   CLK_HZ : clk frequency in Hz
//   BAUD   : serial bit rate
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial line, idle high
//   data      : last correctly framed byte, held until the next one
//   valid     : one-cycle pulse when data is updated
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HalfBit    = half_bit(CLK_HZ, BAUD);

    localparam logic [CntWidth-1:0] BitLast  = CntWidth'(ClksPerBit - 1);
    localparam logic [CntWidth-1:0] HalfLast = CntWidth'(HalfBit - 1);

    if (ClksPerBit < 4 || ClksPerBit > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx: CLK_HZ / BAUD must lie in [4, 65535]");
    end

    logic                rx_s;
    uart_state_e         state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [2:0]          idx_q;
    logic [7:0]          shift_q;
    logic [7:0]          data_q;
    logic                valid_q;
    logic                frame_err_q;

    sync_2ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Single registered FSM; the pulses default low every cycle so each
    // assignment below lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;

            case (state_q)
                StIdle: begin
                    // Also taken the cycle after a valid pulse, so back-to-back
                    // frames need no idle gap.
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end

                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            idx_q   <= '0;
                        end else begin
                            // Line went high again before mid-bit: a glitch.
                            state_q <= StIdle;
                        end
                    end
                end

                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end

                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StWaitHigh;
                        end
                    end
                end

                StWaitHigh: begin
                    // Absorbs a held-low break so it reports one error only.
                    if (rx_s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. A 16-clock bit period keeps frames short
// (CLK_HZ = 1_600_000, BAUD = 100_000, half bit = 8 clocks).
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned TbClkHz = 1_600_000;
    localparam int unsigned TbBaud  = 100_000;
    localparam int          Cpb     = 16;
    localparam int          Half    = 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_HZ (TbClkHz),
        .BAUD   (TbBaud)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor: logs every valid byte with its cycle stamp and counts pulses.
    int         cycle     = 0;
    int         rx_cnt    = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    logic [7:0] rx_log [1024];
    int         stamp  [1024];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (valid) begin
            rx_log[rx_cnt[9:0]] <= data;
            stamp[rx_cnt[9:0]]  <= cycle;
            rx_cnt              <= rx_cnt + 1;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, b0, busy_cycles;
        logic [7:0] exp_bytes [256];

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[5] = '{8'h5A, 1'b0, 8'h01, 0, 1};  // bad stop keeps old data

        // Reset state
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            v0 = rx_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].byte_v, vecs[i].stop_v);
            repeat (2 * Cpb) @(negedge clk);
            check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_valid_count", i), rx_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_count", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy_idle", i), {31'd0, busy}, 32'd0);
        end

        // Back-to-back frames, no idle gap
        v0 = rx_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("b2b_valid_count", rx_cnt - v0, 2);
        check("b2b_ferr_count", ferr_cnt - f0, 0);
        check("b2b_first", {24'd0, rx_log[v0]}, 32'hA5);
        check("b2b_second", {24'd0, rx_log[v0 + 1]}, 32'h3C);
        check("b2b_spacing", stamp[v0 + 1] - stamp[v0], 10 * Cpb);

        // Short low glitch on idle line: busy for exactly one half bit
        v0 = rx_cnt;
        f0 = ferr_cnt;
        busy_cycles = 0;
        rx = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (c == 4) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check("glitch_busy_cycles", busy_cycles, Half);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_valid_count", rx_cnt - v0, 0);
        check("glitch_ferr_count", ferr_cnt - f0, 0);

        // Bad stop bit followed by a 20-bit break
        v0 = rx_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        for (int i = 0; i < 21; i++) send_bit(1'b0);
        check("break_ferr_count", ferr_cnt - f0, 1);
        check("break_valid_count", rx_cnt - v0, 0);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        check("break_data_kept", {24'd0, data}, 32'h3C);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_busy_released", {31'd0, busy}, 32'd0);
        repeat (Cpb) @(negedge clk);
        check("break_no_false_start", rx_cnt - v0 + ferr_cnt - f0, 1);

        // Reset in the middle of bit 4 of 0x81
        v0 = rx_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 1; i < 4; i++) send_bit(1'b0);
        rx = 1'b0;
        repeat (Half) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        check("midrst_no_pulse", rx_cnt - v0 + ferr_cnt - f0, 0);
        send_frame(8'h42, 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("midrst_next_data", {24'd0, data}, 32'h42);
        check("midrst_next_valid", rx_cnt - v0, 1);

        // Random back-to-back stream
        v0 = rx_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 256; i++) exp_bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) send_frame(exp_bytes[i], 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("stream_count", rx_cnt - v0, 256);
        check("stream_ferr", ferr_cnt - f0, 0);
        b0 = 0;
        for (int i = 0; i < 256; i++) begin
            if (rx_log[v0 + i] !== exp_bytes[i]) b0++;
        end
        for (int i = 0; i < 256; i++) begin
            if (rx_log[v0 + i] !== exp_bytes[i] && b0 > 0) begin
                check($sformatf("stream_byte%0d", i), {24'd0, rx_log[v0 + i]},
                      {24'd0, exp_bytes[i]});
                b0 = 0;
            end
        end
        check("stream_mismatch_total", b0, 0);

        check("valid_ferr_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
